// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 8-bit CPU sequencer (states, opcodes, instruction layout).
package cpu_pkg;

   localparam int unsigned PC_W_DEF = 8;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned NREG     = 4;
   localparam int unsigned REG_AW   = 2;
   localparam int unsigned OP_W     = 3;

   // Instruction field positions: [7:5] op, [4:3] rd, [2:1] rs, [0] we
   localparam int unsigned OP_LSB = 5;
   localparam int unsigned RD_LSB = 3;
   localparam int unsigned RS_LSB = 1;
   localparam int unsigned WE_BIT = 0;

   localparam logic [DATA_W-1:0] HALT_INSTR = 8'h00;

   // ALU operation codes carried in the op field
   localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
   localparam logic [OP_W-1:0] OP_AND  = 3'd2;
   localparam logic [OP_W-1:0] OP_OR   = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
   localparam logic [OP_W-1:0] OP_SHR  = 3'd6;
   localparam logic [OP_W-1:0] OP_PASS = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_PAUSE  = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs;
      logic              we;
   } instr_t;

   function automatic logic is_halt(input instr_t instr);
      return instr == instr_t'(HALT_INSTR);
   endfunction

endpackage

// File: rtl/regfile_4x8.sv
// regfile_4x8: 4x8 register file, two asynchronous read ports and one synchronous write port.
module regfile_4x8
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ra_addr,
   input  logic [REG_AW-1:0] rb_addr,
   output logic [DATA_W-1:0] ra_data_c,
   output logic [DATA_W-1:0] rb_data_c,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign ra_data_c = mem[ra_addr];
   assign rb_data_c = mem[rb_addr];

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback controller driving an external ALU.
// Define CPU_SEQ_STEP_EN to add the `step` input and a PAUSE state after every writeback.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W = PC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
`ifdef CPU_SEQ_STEP_EN
   input  logic              step,
`endif
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_valid,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              ld_en,
   input  logic [REG_AW-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   output logic              carry_flag,
   output logic              busy,
   output logic              halted
);

   state_t            state, state_next;
   logic [PC_W-1:0]   pc;
   instr_t            ir;
   logic [DATA_W-1:0] res_data;
   logic              res_carry;

   logic              start_go, fetch_done, load_ops, sample_res, do_wb, preload_ok;
   logic [DATA_W-1:0] rd_data, rs_data;
   logic              wr_en;
   logic [REG_AW-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state logic and per-state datapath strobes
   always_comb begin
      state_next = state;
      start_go   = 1'b0;
      fetch_done = 1'b0;
      load_ops   = 1'b0;
      sample_res = 1'b0;
      do_wb      = 1'b0;
      preload_ok = 1'b0;
      case (state)
         ST_IDLE, ST_HALT: begin
            preload_ok = ld_en;
            if (start) begin
               start_go   = 1'b1;
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (imem_valid) begin
               fetch_done = 1'b1;
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_halt(ir)) begin
               state_next = ST_HALT;
            end else begin
               load_ops   = 1'b1;
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            sample_res = 1'b1;
            state_next = ST_WB;
         end
         ST_WB: begin
            do_wb = 1'b1;
`ifdef CPU_SEQ_STEP_EN
            state_next = ST_PAUSE;
`else
            state_next = ST_FETCH;
`endif
         end
`ifdef CPU_SEQ_STEP_EN
         ST_PAUSE: begin
            if (step) state_next = ST_FETCH;
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath and registered status outputs, all derived from the upcoming state
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= '0;
         ir         <= '0;
         res_data   <= '0;
         res_carry  <= 1'b0;
         carry_flag <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         imem_req   <= 1'b0;
         busy       <= 1'b0;
         halted     <= 1'b0;
      end else begin
         imem_req <= (state_next == ST_FETCH);
         busy     <= (state_next inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_PAUSE});
         halted   <= (state_next == ST_HALT);
         if (start_go) begin
            pc         <= '0;
            carry_flag <= 1'b0;
         end else if (fetch_done) begin
            ir <= instr_t'(imem_rdata);
            pc <= pc + PC_W'(1);
         end
         if (load_ops) begin
            alu_a   <= rd_data;
            alu_b   <= rs_data;
            alu_sel <= ir.op;
         end
         if (sample_res) begin
            res_data  <= alu_result;
            res_carry <= alu_carry;
         end
         if (do_wb) carry_flag <= res_carry;
      end
   end

   assign imem_addr = pc;

   // Single write port shared by writeback and host preload (never active together)
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = ir.rd;
      wr_data = res_data;
      if (do_wb) begin
         wr_en = ir.we;
      end else if (preload_ok) begin
         wr_en   = 1'b1;
         wr_addr = ld_addr;
         wr_data = ld_data;
      end
   end

   regfile_4x8 u_regfile (
      .clk       (clk),
      .rst       (rst),
      .ra_addr   (ir.rd),
      .rb_addr   (ir.rs),
      .ra_data_c (rd_data),
      .rb_data_c (rs_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
   );

endmodule
